mem_port_sched: RTL and testbench

MEM_PORT_SCHED -- requirements
Module: mem_port_sched

---
 rtl/mem_port_sched.sv | 173 +++++++++++++++++
 tb/tb_mem_port_sched.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - byte-serial memory port shared by instruction fetch and load/store unit
//
// Arbitrates between the instruction-fetch (if_*) and load/store (lsb_*) requesters and moves
// each granted access over an 8-bit memory bus, one byte per cycle, little-endian.
//   clk, rst (async, active-low), rdy (global stall), flush (mispredict)
//   if_req/if_addr -> if_done/if_data          : fetch of FETCH_BYTES bytes
//   lsb_req/lsb_we/lsb_addr/lsb_wdata/lsb_size -> lsb_done/lsb_rdata : load/store of 1/2/4 bytes
//   mem_a/mem_dout/mem_wr -> memory, mem_din <- memory (data one cycle after the address)
//   io_buffer_full : UART full, blocks stores to I/O space; busy : transfer in progress
module mem_port_sched #(
    parameter int unsigned FETCH_BYTES = 4,
    parameter logic [1:0]  IO_TAG      = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_we,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    input  logic [2:0]  lsb_size,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    localparam logic [2:0] FETCH_N = 3'(FETCH_BYTES);

    state_t      state_q, state_d;
    logic        owner_lsb_q, owner_lsb_d;   // requester of the transfer in flight
    logic        last_lsb_q, last_lsb_d;     // requester granted most recently
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;               // read bytes assembled so far
    logic [2:0]  n_q, n_d;                   // bytes in this transfer
    logic [2:0]  k_q, k_d;                   // edges since accept
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] lsb_rdata_q, lsb_rdata_d;

    logic        if_ok, lsb_ok, grant_lsb;
    logic [2:0]  lsb_n, k_nxt;
    logic [1:0]  cap_idx;

    always_comb begin
        lsb_n = 3'd4;
        if (lsb_size == 3'd1) lsb_n = 3'd1;
        else if (lsb_size == 3'd2) lsb_n = 3'd2;
    end

    // A flushed fetch request is discarded; an I/O store waits while the UART is full.
    assign if_ok     = if_req & ~flush;
    assign lsb_ok    = lsb_req & ~(lsb_we & (lsb_addr[17:16] == IO_TAG) & io_buffer_full);
    assign grant_lsb = lsb_ok & (~if_ok | ~last_lsb_q);

    assign k_nxt   = k_q + 3'd1;
    // Memory returns data one cycle late, so the byte arriving at edge k belongs to address k-1.
    assign cap_idx = k_q[1:0] - 2'd1;

    always_comb begin
        state_d     = state_q;
        owner_lsb_d = owner_lsb_q;
        last_lsb_d  = last_lsb_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        n_d         = n_q;
        k_d         = k_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        if_data_d   = if_data_q;
        lsb_rdata_d = lsb_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (if_ok || lsb_ok) begin
                    owner_lsb_d = grant_lsb;
                    last_lsb_d  = grant_lsb;
                    addr_d      = grant_lsb ? lsb_addr : if_addr;
                    wdata_d     = lsb_wdata;
                    n_d         = grant_lsb ? lsb_n : FETCH_N;
                    k_d         = 3'd0;
                    buf_d       = 32'd0;
                    mem_a_d     = addr_d;
                    if (grant_lsb && lsb_we) begin
                        mem_dout_d = lsb_wdata[7:0];
                        state_d    = S_WRITE;
                    end else begin
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (k_q != 3'd0) buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
                    if (k_q == n_q) begin
                        state_d = S_DONE;
                        if (owner_lsb_q) lsb_rdata_d = buf_d;
                        else             if_data_d   = buf_d;
                    end else begin
                        k_d = k_nxt;
                        if (k_nxt < n_q) mem_a_d = addr_q + 32'(k_nxt);
                    end
                end
            end
            S_WRITE: begin
                // Stores are committed once started, so flush is ignored here.
                if (k_nxt < n_q) begin
                    k_d        = k_nxt;
                    mem_a_d    = addr_q + 32'(k_nxt);
                    mem_dout_d = wdata_q[{k_nxt[1:0], 3'b000} +: 8];
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            owner_lsb_q <= 1'b0;
            last_lsb_q  <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            n_q         <= 3'd0;
            k_q         <= 3'd0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            if_data_q   <= 32'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy) begin
            state_q     <= state_d;
            owner_lsb_q <= owner_lsb_d;
            last_lsb_q  <= last_lsb_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            n_q         <= n_d;
            k_q         <= k_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            if_data_q   <= if_data_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign if_done   = (state_q == S_DONE) && !owner_lsb_q;
    assign lsb_done  = (state_q == S_DONE) && owner_lsb_q;
    assign mem_wr    = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign mem_a     = mem_a_q;
    assign mem_dout  = mem_dout_q;
    assign if_data   = if_data_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - self-checking bench for mem_port_sched
module tb_mem_port_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req = 1'b0;
    logic        lsb_we = 1'b0;
    logic [31:0] lsb_addr = 32'd0;
    logic [31:0] lsb_wdata = 32'd0;
    logic [2:0]  lsb_size = 3'd4;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;

    // Environment memory (written by the DUT) and reference memory (written by the model).
    logic [7:0] env_mem [65536];
    logic [7:0] ref_mem [65536];

    mem_port_sched #(.FETCH_BYTES(4), .IO_TAG(2'b11)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
        .lsb_size(lsb_size), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rdy) begin
            if (mem_wr) begin
                env_mem[mem_a[15:0]] <= mem_dout;
                wr_cnt <= wr_cnt + 1;
            end
            mem_din <= env_mem[mem_a[15:0]];
        end
    end

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic int nbytes(input logic [2:0] s);
        if (s == 3'd1) return 1;
        if (s == 3'd2) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        logic [31:0] ai;
        r = 32'd0;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            r[8*i +: 8] = ref_mem[ai[15:0]];
        end
        return r;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] wd);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            ref_mem[ai[15:0]] = wd[8*i +: 8];
        end
    endtask

    // Single request; returns edges from accept to done (-1 on timeout) and the done-cycle data.
    task automatic issue(input bit is_lsb, input bit we, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd, output int lat, output logic [31:0] data);
        int t0;
        @(negedge clk);
        if (is_lsb) begin
            lsb_req = 1'b1; lsb_we = we; lsb_addr = a; lsb_size = sz; lsb_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        t0 = cyc;
        lat = -1;
        data = 32'd0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (is_lsb ? lsb_done : if_done) begin
                lat = cyc - t0 - 1;
                data = is_lsb ? lsb_rdata : if_data;
                break;
            end
        end
        lsb_req = 1'b0;
        if_req = 1'b0;
        lsb_we = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr: got %0b want 0", mem_wr); end
        tests++; if (mem_a !== 32'd0) begin fails++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
        tests++; if (mem_dout !== 8'd0) begin fails++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
        tests++; if ({if_done, lsb_done} !== 2'b00) begin fails++; $display("FAIL reset_done: got %b want 00", {if_done, lsb_done}); end
        tests++; if ({if_data, lsb_rdata} !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", {if_data, lsb_rdata}); end
        rst = 1'b1;
    endtask

    task automatic test_fetch;
        env_mem[16'h0100] = 8'h13; env_mem[16'h0101] = 8'h00; env_mem[16'h0102] = 8'h00; env_mem[16'h0103] = 8'h00;
        ref_mem[16'h0100] = 8'h13; ref_mem[16'h0101] = 8'h00; ref_mem[16'h0102] = 8'h00; ref_mem[16'h0103] = 8'h00;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (mem_a !== 32'h100 + 32'(i) || mem_wr !== 1'b0 || if_done !== 1'b0) begin
                fails++; $display("FAIL fetch_addr%0d: got a=%h wr=%0b done=%0b want a=%h wr=0 done=0",
                                  i, mem_a, mem_wr, if_done, 32'h100 + 32'(i));
            end
        end
        @(negedge clk);
        tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL fetch_early_done: got %0b want 0", if_done); end
        @(negedge clk);
        tests++; if (if_done !== 1'b1) begin fails++; $display("FAIL fetch_done: got %0b want 1", if_done); end
        tests++; if (if_data !== ref_read(32'h100, 4)) begin fails++; $display("FAIL fetch_data: got %h want %h", if_data, ref_read(32'h100, 4)); end
        if_req = 1'b0;
        @(negedge clk);
        tests++; if (if_done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL fetch_pulse: got done=%0b busy=%0b want 0 0", if_done, busy); end
        tests++; if (if_data !== 32'h13) begin fails++; $display("FAIL fetch_hold: got %h want 00000013", if_data); end
    endtask

    task automatic test_round_robin;
        int t_lsb, t_if;
        logic [31:0] d_lsb, d_if;
        logic idle4;
        t_lsb = -1; t_if = -1; d_lsb = 32'd0; d_if = 32'd0; idle4 = 1'b0;
        @(negedge clk);
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h200; lsb_size = 3'd2;
        if_req = 1'b1; if_addr = 32'h300;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 4) idle4 = ~busy;
            if (lsb_done && t_lsb < 0) begin t_lsb = c; d_lsb = lsb_rdata; lsb_req = 1'b0; end
            if (if_done && t_if < 0) begin t_if = c; d_if = if_data; if_req = 1'b0; end
        end
        lsb_req = 1'b0; if_req = 1'b0;
        tests++; if (t_lsb != 3) begin fails++; $display("FAIL rr_lsb_time: got %0d want 3", t_lsb); end
        tests++; if (d_lsb !== ref_read(32'h200, 2)) begin fails++; $display("FAIL rr_lsb_data: got %h want %h", d_lsb, ref_read(32'h200, 2)); end
        tests++; if (idle4 !== 1'b1) begin fails++; $display("FAIL rr_idle_gap: got idle=%0b want 1", idle4); end
        tests++; if (t_if != 10) begin fails++; $display("FAIL rr_if_time: got %0d want 10", t_if); end
        tests++; if (d_if !== ref_read(32'h300, 4)) begin fails++; $display("FAIL rr_if_data: got %h want %h", d_if, ref_read(32'h300, 4)); end
    endtask

    task automatic test_io_stall;
        @(negedge clk);
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_size = 3'd1; lsb_wdata = 32'h41;
        io_buffer_full = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            tests++;
            if (mem_wr !== 1'b0 || busy !== 1'b0) begin
                fails++; $display("FAIL io_stall%0d: got wr=%0b busy=%0b want 0 0", c, mem_wr, busy);
            end
        end
        io_buffer_full = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h30000 || mem_dout !== 8'h41 || lsb_done !== 1'b0) begin
            fails++; $display("FAIL io_write: got wr=%0b a=%h d=%h done=%0b want 1 30000 41 0", mem_wr, mem_a, mem_dout, lsb_done);
        end
        @(negedge clk);
        tests++;
        if (lsb_done !== 1'b1 || mem_wr !== 1'b0) begin
            fails++; $display("FAIL io_done: got done=%0b wr=%0b want 1 0", lsb_done, mem_wr);
        end
        lsb_req = 1'b0; lsb_we = 1'b0;
        ref_store(32'h30000, 1, 32'h41);
        tests++; if (env_mem[16'h0000] !== 8'h41) begin fails++; $display("FAIL io_mem: got %h want 41", env_mem[16'h0000]); end
    endtask

    task automatic test_flush;
        int ndone;
        int lat;
        logic [31:0] d;
        ndone = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h400;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (if_done) ndone++;
            if (c == 2) flush = 1'b1;
            if (c == 3) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_abort: got busy=%0b want 0", busy); end
            end
            if (c == 4) begin
                tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_drop_req: got busy=%0b want 0", busy); end
                flush = 1'b0; if_req = 1'b0;
            end
        end
        tests++; if (ndone != 0) begin fails++; $display("FAIL flush_no_done: got %0d pulses want 0", ndone); end
        issue(1'b0, 1'b0, 32'h0, 3'd4, 32'd0, lat, d);
        tests++; if (lat != 5) begin fails++; $display("FAIL flush_refetch_lat: got %0d want 5", lat); end
        tests++; if (d !== ref_read(32'h0, 4)) begin fails++; $display("FAIL flush_refetch_data: got %h want %h", d, ref_read(32'h0, 4)); end
    endtask

    task automatic test_rdy_pause;
        int t_done;
        logic [31:0] a_saved, d;
        t_done = -1; a_saved = 32'd0; d = 32'd0;
        @(negedge clk);
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h500; lsb_size = 3'd4;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (lsb_done && t_done < 0) begin t_done = c; d = lsb_rdata; lsb_req = 1'b0; end
            if (c >= 2 && c <= 5) begin
                tests++;
                if (mem_a !== a_saved) begin fails++; $display("FAIL rdy_freeze%0d: got %h want %h", c, mem_a, a_saved); end
            end
            if (c == 1) begin a_saved = mem_a; rdy = 1'b0; end
            if (c == 5) rdy = 1'b1;
        end
        lsb_req = 1'b0;
        tests++; if (t_done != 9) begin fails++; $display("FAIL rdy_done_time: got %0d want 9", t_done); end
        tests++; if (d !== ref_read(32'h500, 4)) begin fails++; $display("FAIL rdy_data: got %h want %h", d, ref_read(32'h500, 4)); end
    endtask

    task automatic test_reset_mid_store;
        int ndone;
        int lat;
        logic [31:0] d;
        ndone = 0;
        @(negedge clk);
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h600; lsb_size = 3'd4; lsb_wdata = $urandom;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        tests++;
        if (mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_dout !== 8'd0 || busy !== 1'b0) begin
            fails++; $display("FAIL rst_async_bus: got wr=%0b a=%h d=%h busy=%0b want all 0", mem_wr, mem_a, mem_dout, busy);
        end
        tests++;
        if (if_data !== 32'd0 || lsb_rdata !== 32'd0 || lsb_done !== 1'b0 || if_done !== 1'b0) begin
            fails++; $display("FAIL rst_async_out: got if_data=%h lsb_rdata=%h done=%b want 0", if_data, lsb_rdata, {if_done, lsb_done});
        end
        lsb_req = 1'b0; lsb_we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (lsb_done) ndone++;
        end
        tests++; if (ndone != 0) begin fails++; $display("FAIL rst_no_done: got %0d pulses want 0", ndone); end
        issue(1'b0, 1'b0, 32'h700, 3'd4, 32'd0, lat, d);
        tests++; if (lat != 5) begin fails++; $display("FAIL rst_first_lat: got %0d want 5", lat); end
        tests++; if (d !== ref_read(32'h700, 4)) begin fails++; $display("FAIL rst_first_data: got %h want %h", d, ref_read(32'h700, 4)); end
    endtask

    task automatic test_random;
        int lat, n, exp_lat, w0, exp_wr;
        logic [31:0] a, wd, d, exp_d;
        logic [2:0] sz;
        int kind;
        exp_wr = 0;
        w0 = wr_cnt;
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            sz = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 4) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else a = 32'h1000 + 32'($urandom_range(0, 255));
            n = (kind == 0) ? 4 : nbytes(sz);
            issue(kind != 0, kind == 2, a, sz, wd, lat, d);
            exp_lat = (kind == 2) ? n : n + 1;
            tests++;
            if (lat != exp_lat) begin
                fails++; $display("FAIL rand%0d_lat: kind=%0d a=%h got %0d want %0d", t, kind, a, lat, exp_lat);
            end
            if (kind == 2) begin
                ref_store(a, n, wd);
                exp_wr += n;
            end else begin
                exp_d = ref_read(a, n);
                tests++;
                if (d !== exp_d) begin
                    fails++; $display("FAIL rand%0d_data: kind=%0d a=%h n=%0d got %h want %h", t, kind, a, n, d, exp_d);
                end
            end
        end
        @(negedge clk);
        tests++;
        if (wr_cnt - w0 != exp_wr) begin
            fails++; $display("FAIL rand_write_cycles: got %0d want %0d", wr_cnt - w0, exp_wr);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = pat(32'(i));
            ref_mem[i] = pat(32'(i));
        end
        test_reset;
        test_fetch;
        test_round_robin;
        test_io_stall;
        test_flush;
        test_rdy_pause;
        test_reset_mid_store;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
